rgb_hsv_pipe: RTL and testbench

RGB_HSV_PIPE -- requirements
Module: rgb_hsv_pipe

---
 rtl/rgb_hsv_pipe.sv | 172 +++++++++++++++++
 tb/tb_rgb_hsv_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_hsv_pipe.sv
// Six-stage streaming RGB -> HSV converter with one global stall enable and sideband passthrough.
// Stages: 1 capture, 2 max/min, 3 hue numerator, 4 hue divide, 5 saturation divide, 6 output.
module rgb_hsv_pipe #(
  parameter int DW    = 8,
  parameter int HUE_W = 8,
  parameter int SB_W  = 2
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_red,
  input  logic [DW-1:0]    in_green,
  input  logic [DW-1:0]    in_blue,
  input  logic [SB_W-1:0]  in_sb,
  input  logic             cfg_hue_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_red,
  output logic [DW-1:0]    out_green,
  output logic [DW-1:0]    out_blue,
  output logic [HUE_W-1:0] out_hue,
  output logic [DW-1:0]    out_sat,
  output logic [DW-1:0]    out_val,
  output logic [SB_W-1:0]  out_sb
);
  localparam int NS = 6;
  localparam int HW = DW + 3;     // holds 6*delta
  localparam int MW = HUE_W + 1;  // holds HMAX = 2^HUE_W
  localparam int PW = HW + MW;    // holds h6*HMAX without truncation
  localparam int SW = 2 * DW;

  typedef enum logic [1:0] {SEL_R, SEL_G, SEL_B} sel_t;

  logic            en;
  logic [NS-1:0]   vld_reg;
  logic [DW-1:0]   red_reg   [NS];
  logic [DW-1:0]   green_reg [NS];
  logic [DW-1:0]   blue_reg  [NS];
  logic [SB_W-1:0] sb_reg    [NS];

  logic             mode1_reg, mode2_reg;
  sel_t             sel2_reg;
  logic [DW-1:0]    max2_reg, delta2_reg;
  logic [PW-1:0]    num3_reg;
  logic [HW-1:0]    den3_reg;
  logic [DW-1:0]    max3_reg, delta3_reg;
  logic [HUE_W-1:0] hue4_reg, hue5_reg, hue6_reg;
  logic [DW-1:0]    max4_reg, delta4_reg, max5_reg, sat5_reg, sat6_reg, val6_reg;

  sel_t             sel_next;
  logic [DW-1:0]    max_next, min_next;
  logic [HW-1:0]    d_ext, r_ext, g_ext, b_ext, h6_next;
  logic [MW-1:0]    hmax_next;
  logic [HUE_W-1:0] hue_next;
  logic [DW-1:0]    sat_next;

  assign en        = out_ready | ~vld_reg[NS-1];
  assign in_ready  = en;
  assign out_valid = vld_reg[NS-1];

  // Max ties resolve red > blue > green; min ties green > blue > red.
  always_comb begin
    sel_next = SEL_R;
    max_next = red_reg[0];
    if (red_reg[0] >= green_reg[0] && red_reg[0] >= blue_reg[0]) begin
      sel_next = SEL_R;
      max_next = red_reg[0];
    end else if (blue_reg[0] >= green_reg[0]) begin
      sel_next = SEL_B;
      max_next = blue_reg[0];
    end else begin
      sel_next = SEL_G;
      max_next = green_reg[0];
    end
    if (green_reg[0] <= red_reg[0] && green_reg[0] <= blue_reg[0])
      min_next = green_reg[0];
    else if (blue_reg[0] <= red_reg[0])
      min_next = blue_reg[0];
    else
      min_next = red_reg[0];
  end

  // Sector numerator in modular HW-bit arithmetic; the final value is always in [0, 6*delta).
  always_comb begin
    d_ext = HW'(delta2_reg);
    r_ext = HW'(red_reg[1]);
    g_ext = HW'(green_reg[1]);
    b_ext = HW'(blue_reg[1]);
    case (sel2_reg)
      SEL_G:   h6_next = (d_ext << 1) + b_ext - r_ext;
      SEL_B:   h6_next = (d_ext << 2) + r_ext - g_ext;
      default: h6_next = (g_ext >= b_ext) ? (g_ext - b_ext) : (d_ext * HW'(6)) + g_ext - b_ext;
    endcase
    hmax_next = mode2_reg ? MW'(180) : (MW'(1) << HUE_W);
  end

  always_comb begin
    hue_next = (den3_reg == '0) ? '0 : HUE_W'(num3_reg / PW'(den3_reg));
    sat_next = (max4_reg == '0) ? '0
             : DW'((SW'({DW{1'b1}}) * SW'(delta4_reg)) / SW'(max4_reg));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_reg <= '0;
      for (int i = 0; i < NS; i++) begin
        red_reg[i]   <= '0;
        green_reg[i] <= '0;
        blue_reg[i]  <= '0;
        sb_reg[i]    <= '0;
      end
      mode1_reg  <= 1'b0;
      mode2_reg  <= 1'b0;
      sel2_reg   <= SEL_R;
      max2_reg   <= '0;
      delta2_reg <= '0;
      num3_reg   <= '0;
      den3_reg   <= '0;
      max3_reg   <= '0;
      delta3_reg <= '0;
      hue4_reg   <= '0;
      max4_reg   <= '0;
      delta4_reg <= '0;
      hue5_reg   <= '0;
      sat5_reg   <= '0;
      max5_reg   <= '0;
      hue6_reg   <= '0;
      sat6_reg   <= '0;
      val6_reg   <= '0;
    end else if (en) begin
      vld_reg      <= {vld_reg[NS-2:0], in_valid};
      red_reg[0]   <= in_red;
      green_reg[0] <= in_green;
      blue_reg[0]  <= in_blue;
      sb_reg[0]    <= in_sb;
      for (int i = 1; i < NS; i++) begin
        red_reg[i]   <= red_reg[i-1];
        green_reg[i] <= green_reg[i-1];
        blue_reg[i]  <= blue_reg[i-1];
        sb_reg[i]    <= sb_reg[i-1];
      end
      mode1_reg  <= cfg_hue_mode;
      mode2_reg  <= mode1_reg;
      sel2_reg   <= sel_next;
      max2_reg   <= max_next;
      delta2_reg <= max_next - min_next;
      num3_reg   <= PW'(h6_next) * PW'(hmax_next);
      den3_reg   <= d_ext * HW'(6);
      max3_reg   <= max2_reg;
      delta3_reg <= delta2_reg;
      hue4_reg   <= hue_next;
      max4_reg   <= max3_reg;
      delta4_reg <= delta3_reg;
      hue5_reg   <= hue4_reg;
      sat5_reg   <= sat_next;
      max5_reg   <= max4_reg;
      hue6_reg   <= hue5_reg;
      sat6_reg   <= sat5_reg;
      val6_reg   <= max5_reg;
    end
  end

  assign out_red   = red_reg[NS-1];
  assign out_green = green_reg[NS-1];
  assign out_blue  = blue_reg[NS-1];
  assign out_sb    = sb_reg[NS-1];
  assign out_hue   = hue6_reg;
  assign out_sat   = sat6_reg;
  assign out_val   = val6_reg;

endmodule

// File: tb/tb_rgb_hsv_pipe.sv
// Directed bench for rgb_hsv_pipe: single pixels, streams with backpressure and mode toggles,
// and a reset with pixels in flight. Expected hue/sat/val values are hand-computed constants.
module tb_rgb_hsv_pipe;
  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_red = '0, in_green = '0, in_blue = '0;
  logic [1:0] in_sb = '0;
  logic       cfg_hue_mode = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_red, out_green, out_blue, out_hue, out_sat, out_val;
  logic [1:0] out_sb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] r, g, b;
    logic       m;
    logic [7:0] hue, sat, val;
  } vec_t;

  vec_t vt [17];
  int   sq [$];
  int   list_a [10] = '{0, 2, 3, 6, 7, 9, 10, 11, 14, 13};
  int   list_b [7]  = '{1, 2, 3, 4, 16, 5, 6};

  always #5 clk = ~clk;

  rgb_hsv_pipe #(.DW(8), .HUE_W(8), .SB_W(2)) dut (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
    .in_sb(in_sb), .cfg_hue_mode(cfg_hue_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .out_hue(out_hue), .out_sat(out_sat), .out_val(out_val), .out_sb(out_sb)
  );

  function automatic vec_t mk(int r, int g, int b, int m, int h, int s, int v);
    vec_t x;
    x.r = 8'(r); x.g = 8'(g); x.b = 8'(b); x.m = 1'(m);
    x.hue = 8'(h); x.sat = 8'(s); x.val = 8'(v);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic [1:0] sb);
    in_red = vt[i].r; in_green = vt[i].g; in_blue = vt[i].b;
    cfg_hue_mode = vt[i].m; in_sb = sb; in_valid = 1'b1;
  endtask

  task automatic chk_out(input string tag, input int i, input logic [1:0] sb);
    chk({tag, ".hue"},   out_hue,   vt[i].hue);
    chk({tag, ".sat"},   out_sat,   vt[i].sat);
    chk({tag, ".val"},   out_val,   vt[i].val);
    chk({tag, ".red"},   out_red,   vt[i].r);
    chk({tag, ".green"}, out_green, vt[i].g);
    chk({tag, ".blue"},  out_blue,  vt[i].b);
    chk({tag, ".sb"},    out_sb,    sb);
    $display("pix %s vec=%0d rgb=(%0d,%0d,%0d) mode=%0d -> hue=%0d sat=%0d val=%0d sb=%0d",
             tag, i, out_red, out_green, out_blue, vt[i].m, out_hue, out_sat, out_val, out_sb);
  endtask

  // One pixel into an idle pipeline; measures the cycle count from the accepting edge.
  task automatic send_one(input int i, input logic [1:0] sb);
    int cyc;
    string tag;
    tag = $sformatf("v%0d", i);
    @(negedge clk);
    out_ready = 1'b1;
    drive(i, sb);
    #1;
    chk({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, cyc, 6);
    if (out_valid) chk_out(tag, i, sb);
  endtask

  // Continuous stream of the vectors in sq; optional 3-cycle out_ready drop mid-stream.
  task automatic run_stream(input string name, input bit stall);
    int k_in, k_out, n;
    logic [7:0] snap_hue, snap_red;
    logic [1:0] snap_sb;
    k_in = 0; k_out = 0; n = sq.size();
    snap_hue = '0; snap_red = '0; snap_sb = '0;
    for (int cyc = 0; cyc < 100 && k_out < n; cyc++) begin
      @(negedge clk);
      out_ready = !(stall && cyc >= 8 && cyc <= 10);
      if (k_in < n) drive(sq[k_in], 2'(k_in));
      else in_valid = 1'b0;
      #1;
      if (stall && cyc == 8) begin
        chk({name, ".stall_valid"}, out_valid, 1);
        snap_hue = out_hue; snap_red = out_red; snap_sb = out_sb;
      end
      if (stall && cyc >= 8 && cyc <= 10)
        chk($sformatf("%s.in_ready@%0d", name, cyc), in_ready, 0);
      if (stall && (cyc == 9 || cyc == 10)) begin
        chk($sformatf("%s.frozen_valid@%0d", name, cyc), out_valid, 1);
        chk($sformatf("%s.frozen_hue@%0d", name, cyc), out_hue, snap_hue);
        chk($sformatf("%s.frozen_red@%0d", name, cyc), out_red, snap_red);
        chk($sformatf("%s.frozen_sb@%0d", name, cyc), out_sb, snap_sb);
      end
      if (in_valid && in_ready) k_in++;
      if (out_valid && out_ready) begin
        chk_out($sformatf("%s%0d", name, k_out), sq[k_out], 2'(k_out));
        k_out++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({name, ".count"}, k_out, n);
  endtask

  initial begin
    int seen;
    vt[0]  = mk(255,   0,   0, 0,   0, 255, 255);
    vt[1]  = mk(  0, 255,   0, 0,  85, 255, 255);
    vt[2]  = mk(  0, 255,   0, 1,  60, 255, 255);
    vt[3]  = mk(  0,   0, 255, 0, 170, 255, 255);
    vt[4]  = mk(  0,   0, 255, 1, 120, 255, 255);
    vt[5]  = mk(255,   0, 255, 0, 213, 255, 255);
    vt[6]  = mk(255,   0, 255, 1, 150, 255, 255);
    vt[7]  = mk(128, 128, 128, 0,   0,   0, 128);
    vt[8]  = mk(  0,   0,   0, 0,   0,   0,   0);
    vt[9]  = mk(200, 100,  50, 0,  14, 191, 200);
    vt[10] = mk(100, 200,  50, 0,  71, 191, 200);
    vt[11] = mk( 50, 100, 200, 1, 110, 191, 200);
    vt[12] = mk( 10,  20,  30, 0, 149, 170,  30);
    vt[13] = mk(200,  50, 100, 0, 241, 191, 200);
    vt[14] = mk(255, 255,   0, 1,  30, 255, 255);
    vt[15] = mk(  1,   0,   0, 0,   0, 255,   1);
    vt[16] = mk(  0, 255, 255, 0, 128, 255, 255);

    // Reset state, with a pixel offered that must not be taken.
    drive(0, 2'b11);
    repeat (2) @(negedge clk);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_hue", out_hue, 0);
    chk("rst.out_sat", out_sat, 0);
    chk("rst.out_val", out_val, 0);
    chk("rst.out_red", out_red, 0);
    chk("rst.out_sb", out_sb, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < 17; i++)
      send_one(i, (i == 9) ? 2'b10 : 2'(i));

    sq.delete();
    foreach (list_a[j]) sq.push_back(list_a[j]);
    run_stream("bp", 1'b1);

    sq.delete();
    foreach (list_b[j]) sq.push_back(list_b[j]);
    run_stream("mode", 1'b0);

    // Four pixels in flight, head held at the output, then a one-cycle reset.
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(12 + k, 2'(3 - k));
      @(negedge clk);
    end
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 10) begin
      @(negedge clk);
      seen++;
    end
    chk("mid.pre_valid", out_valid, 1);
    chk("mid.pre_hue", out_hue, 149);
    #1;
    rst_l = 1'b0;
    drive(8, 2'b01);
    out_ready = 1'b1;
    #1;
    chk("mid.out_valid", out_valid, 0);
    chk("mid.in_ready", in_ready, 1);
    chk("mid.out_hue", out_hue, 0);
    chk("mid.out_val", out_val, 0);
    chk("mid.out_red", out_red, 0);
    chk("mid.out_sb", out_sb, 0);
    @(negedge clk);
    rst_l = 1'b1;
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid.ghost_outputs", seen, 0);
    send_one(9, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
